// File: rtl/rv32_pkg.sv
// Shared RV32I constants for the writeback path: widths, result-select
// codes, load funct3 codes and writeback FSM state encoding.
package rv32_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    localparam logic [1:0] RES_ALU  = 2'd0;
    localparam logic [1:0] RES_LOAD = 2'd1;
    localparam logic [1:0] RES_PC4  = 2'd2;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [0:0] WB_IDLE      = 1'b0;
    localparam logic [0:0] WB_WAIT_LOAD = 1'b1;

endpackage

// File: rtl/load_align.sv
// Combinational RV32I load extraction: picks the byte/half addressed by
// addr out of an aligned word, extends it, and flags misaligned accesses.
module load_align
    import rv32_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] data,
    output logic            misaligned
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = rdata[7:0];
        case (addr)
            2'd0:    byte_v = rdata[7:0];
            2'd1:    byte_v = rdata[15:8];
            2'd2:    byte_v = rdata[23:16];
            default: byte_v = rdata[31:24];
        endcase
        half_v = addr[1] ? rdata[31:16] : rdata[15:0];
    end

    // Unknown funct3 values fall through to the word case, both for data and alignment.
    always_comb begin
        data       = rdata;
        misaligned = 1'b0;
        case (funct3)
            F3_LB:  data = {{(XLEN-8){byte_v[7]}}, byte_v};
            F3_LBU: data = {{(XLEN-8){1'b0}}, byte_v};
            F3_LH: begin
                data       = {{(XLEN-16){half_v[15]}}, half_v};
                misaligned = addr[0];
            end
            F3_LHU: begin
                data       = {{(XLEN-16){1'b0}}, half_v};
                misaligned = addr[0];
            end
            default: begin
                data       = rdata;
                misaligned = (addr != 2'd0);
            end
        endcase
    end

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: selects the result, waits on variable-latency load data,
// and drives a registered one-cycle register-bank write plus forwarding copy.
module writeback_unit
    import rv32_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_valid,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_reg_write,
    input  logic [1:0]        wb_res_sel,
    input  logic [XLEN-1:0]   wb_alu_result,
    input  logic [XLEN-1:0]   wb_pc_plus4,
    input  logic [2:0]        wb_funct3,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic [REG_AW-1:0] rd,
    output logic              RegWrite,
    output logic [XLEN-1:0]   C,
    output logic              stall,
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_rd,
    output logic [XLEN-1:0]   fwd_data,
    output logic              load_misalign
);

    // Handshake: wb_valid is sampled only in IDLE (stall low); mem_rvalid is a
    // single-cycle response sampled only in WAIT_LOAD, never in the accept cycle.
    logic [0:0]        state;
    logic [REG_AW-1:0] lat_rd;
    logic              lat_we;
    logic [2:0]        lat_f3;
    logic [1:0]        lat_addr;

    logic [2:0]        la_f3;
    logic [1:0]        la_addr;
    logic [XLEN-1:0]   la_data;
    logic              la_mis;
    logic [XLEN-1:0]   sel_value;

    // In IDLE the aligner only checks the incoming load; in WAIT_LOAD it extracts the latched one.
    always_comb begin
        la_f3     = (state == WB_IDLE) ? wb_funct3 : lat_f3;
        la_addr   = (state == WB_IDLE) ? wb_alu_result[1:0] : lat_addr;
        sel_value = (wb_res_sel == RES_PC4) ? wb_pc_plus4 : wb_alu_result;
    end

    load_align u_align (
        .funct3     (la_f3),
        .addr       (la_addr),
        .rdata      (mem_rdata),
        .data       (la_data),
        .misaligned (la_mis)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= WB_IDLE;
            rd            <= '0;
            RegWrite      <= 1'b0;
            C             <= '0;
            load_misalign <= 1'b0;
            lat_rd        <= '0;
            lat_we        <= 1'b0;
            lat_f3        <= '0;
            lat_addr      <= '0;
        end else begin
            RegWrite      <= 1'b0;
            load_misalign <= 1'b0;
            if (state == WB_IDLE) begin
                if (wb_valid) begin
                    if (wb_res_sel == RES_LOAD) begin
                        if (la_mis) begin
                            load_misalign <= 1'b1;
                        end else begin
                            lat_rd   <= wb_rd;
                            lat_we   <= wb_reg_write;
                            lat_f3   <= wb_funct3;
                            lat_addr <= wb_alu_result[1:0];
                            state    <= WB_WAIT_LOAD;
                        end
                    end else begin
                        rd       <= wb_rd;
                        RegWrite <= wb_reg_write && (wb_rd != '0);
                        C        <= sel_value;
                    end
                end
            end else begin
                if (mem_rvalid) begin
                    rd       <= lat_rd;
                    RegWrite <= lat_we && (lat_rd != '0);
                    C        <= la_data;
                    state    <= WB_IDLE;
                end
            end
        end
    end

    assign stall     = (state == WB_WAIT_LOAD);
    assign fwd_valid = RegWrite;
    assign fwd_rd    = rd;
    assign fwd_data  = C;

endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Write-side master for the register bank; sits between the MEM/WB pipeline register and the bank's write port.
- Selects the result source (ALU result, load data, PC+4).
- Aligns and sign- or zero-extends RV32I load data.
- Waits on a variable-latency data-memory read response, stalling the pipeline until it arrives.
- Drives rd/RegWrite/C for one cycle per committed instruction and mirrors that write onto a forwarding bus.

Parameters:
- XLEN, 32, data width of results and register contents.
- REG_AW, 5, register address width.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- wb_valid  input  1  instruction present in MEM/WB.
- wb_rd  input  REG_AW  destination register.
- wb_reg_write  input  1  instruction writes a register.
- wb_res_sel  input  2  result source: 0 ALU, 1 load, 2 PC+4, 3 reserved (treated as ALU).
- wb_alu_result  input  XLEN  ALU result; for loads, the effective address.
- wb_pc_plus4  input  XLEN  link value for JAL/JALR.
- wb_funct3  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- mem_rvalid  input  1  data-memory read response valid.
- mem_rdata  input  XLEN  aligned 32-bit word from data memory.
- rd  output  REG_AW  to register bank.
- RegWrite  output  1  to register bank.
- C  output  XLEN  to register bank.
- stall  output  1  freezes IF..MEM/WB while waiting on a load.
- fwd_valid  output  1  forwarding bus valid (equals RegWrite).
- fwd_rd  output  REG_AW  forwarding destination.
- fwd_data  output  XLEN  forwarding value.
- load_misalign  output  1  one-cycle pulse on a misaligned load.

Behaviour:
- Reset (sync, rst=1 at posedge):
  - state=IDLE.
  - rd=0, RegWrite=0, C=0, fwd_*=0, load_misalign=0.
  - stall=0.
  - Reset mid-WAIT_LOAD abandons the load; a later mem_rvalid is ignored.
- All write-port outputs are registered. Commit appears the cycle after acceptance (ALU/PC+4) or after mem_rvalid (load).
- RegWrite is high for exactly one cycle per commit. It is never asserted when rd==0, so the x0 write is suppressed here as well as in the bank.
- States:
  - IDLE:
    - wb_valid && res_sel!=1: next cycle RegWrite=wb_reg_write&&(wb_rd!=0), C=selected value, rd=wb_rd. Stay IDLE.
    - wb_valid && res_sel==1 && misaligned (LH/LHU with addr[0]=1, LW with addr[1:0]!=0): next cycle load_misalign=1, RegWrite=0. Stay IDLE.
    - wb_valid && res_sel==1 && aligned: latch rd, reg_write, funct3 and addr[1:0]; go WAIT_LOAD.
  - WAIT_LOAD:
    - stall=1, combinational from state.
    - On mem_rvalid: extract, commit next cycle, go IDLE. stall drops in the cycle after mem_rvalid.
    - Inputs on wb_* are ignored while in WAIT_LOAD.
  - If mem_rvalid arrives in the same cycle the load is accepted in IDLE, it is ignored. The response must come at least one cycle later.
- Load extraction:
  - byte = rdata[8*addr+7 : 8*addr].
  - half = rdata[16*addr[1]+15 : 16*addr[1]].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
  - Undefined funct3 is treated as LW.
- mem_rvalid while IDLE is ignored.
- Throughput: one ALU/PC+4 commit per cycle. Back-to-back loads each incur the wait.

Decomposition:
- Shared package rv32_pkg:
  - XLEN, REG_AW.
  - Result-select constants RES_ALU, RES_LOAD, RES_PC4.
  - funct3 load constants F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU.
  - State encoding WB_IDLE, WB_WAIT_LOAD.
- One sub-module: load_align, a purely combinational block taking (funct3, addr[1:0], rdata) and producing (data, misaligned).

Test Plan:
- ALU commit: wb_valid=1, res_sel=0, rd=5, alu=0x0000_1234 -> next cycle RegWrite=1, rd=5, C=0x1234, fwd mirrors it, stall=0.
- x0 suppression: rd=0, res_sel=2, pc_plus4=0x104 -> RegWrite=0 and fwd_valid=0 throughout.
- LB sign-extend: addr=0x...3, funct3=000, mem_rvalid 3 cycles later with rdata=0x80FF_0000 -> stall=1 for 3 cycles, then RegWrite=1 with C=0xFFFF_FF80.
- LHU zero-extend: addr[1:0]=2, rdata=0xBEEF_1234 -> C=0x0000_BEEF. LH with the same inputs -> C=0xFFFF_BEEF.
- Misaligned LW: addr[1:0]=1 -> load_misalign pulses for one cycle, RegWrite=0, no stall.
- Reset mid-load: rst asserted during WAIT_LOAD, then mem_rvalid=1 -> stall=0, RegWrite never asserts, state returns to IDLE.
